// File: rtl/sram_s011hd1p_x32y2d128_bw.sv
// rtl/sram_s011hd1p_x32y2d128_bw.sv - 64x128 single-port synchronous SRAM model with per-bit write enable
module sram_s011hd1p_x32y2d128_bw #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  CEN,
    input  logic                  WEN,
    input  logic [DATA_WIDTH-1:0] BWEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] q_d;

    // Decode the single-port operation: idle, read into Q, or bit-masked write.
    // The default arm is only reachable with X/Z on CEN/WEN in a four-state
    // simulator; Q goes unknown and the array is left untouched.
    always_comb begin
        mem_d = mem_q;
        q_d   = q_q;
        case ({CEN, WEN})
            2'b00: mem_d[A] = (D & ~BWEN) | (mem_q[A] & BWEN);
            2'b01: q_d = mem_q[A];
            2'b10,
            2'b11: q_d = q_q;
            default: q_d = 'x;
        endcase
    end

    // Array and output register; reset clears every word and Q immediately.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            q_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_sram_s011hd1p_x32y2d128_bw.sv
// tb/tb_sram_s011hd1p_x32y2d128_bw.sv - directed self-checking bench for the 64x128 bit-write SRAM
module tb_sram_s011hd1p_x32y2d128_bw;

    logic         CLK;
    logic         RSTN;
    logic         CEN;
    logic         WEN;
    logic [127:0] BWEN;
    logic [5:0]   A;
    logic [127:0] D;
    logic [127:0] Q;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] D1     = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] ONES   = {128{1'b1}};
    localparam logic [127:0] MASKED = 128'hFFFFFFFF_FFFFFF88_FFFFFFFF_FFFFFFFF;
    localparam logic [127:0] P5A    = {16{8'h5A}};

    sram_s011hd1p_x32y2d128_bw #(
        .ADDR_WIDTH(6),
        .DATA_WIDTH(128)
    ) dut (
        .CLK (CLK),
        .RSTN(RSTN),
        .CEN (CEN),
        .WEN (WEN),
        .BWEN(BWEN),
        .A   (A),
        .D   (D),
        .Q   (Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one operation at the falling edge, let the rising edge sample it,
    // and return 1ns after that edge.
    task automatic do_op(input logic cen, input logic wen, input logic [127:0] bwen,
                         input logic [5:0] addr, input logic [127:0] data);
        @(negedge CLK);
        CEN  = cen;
        WEN  = wen;
        BWEN = bwen;
        A    = addr;
        D    = data;
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [5:0] addr, input logic [127:0] data, input logic [127:0] bwen);
        do_op(1'b0, 1'b0, bwen, addr, data);
    endtask

    task automatic rd(input logic [5:0] addr);
        do_op(1'b0, 1'b1, ONES, addr, '0);
    endtask

    task automatic idle();
        do_op(1'b1, 1'b1, ONES, '0, '0);
    endtask

    initial begin
        logic [127:0] pat;
        logic [5:0]   addrs [4];
        addrs[0] = 6'h00;
        addrs[1] = 6'h01;
        addrs[2] = 6'h3E;
        addrs[3] = 6'h3F;

        RSTN = 1'b0;
        CEN  = 1'b1;
        WEN  = 1'b1;
        BWEN = ONES;
        A    = '0;
        D    = '0;

        // Reset held for two cycles with a read request presented: edges ignored.
        do_op(1'b0, 1'b1, ONES, 6'h00, '0);
        check_eq("reset_q_c1", Q, '0);
        do_op(1'b0, 1'b0, '0, 6'h05, D1);
        check_eq("reset_q_c2", Q, '0);
        @(negedge CLK);
        RSTN = 1'b1;

        rd(6'h00);
        check_eq("first_read_00", Q, '0);
        rd(6'h3F);
        check_eq("first_read_3f", Q, '0);

        // Full write then read latency.
        wr(6'h05, D1, '0);
        check_eq("q_held_on_write", Q, '0);
        @(negedge CLK);
        CEN = 1'b0; WEN = 1'b1; A = 6'h05; BWEN = ONES; D = '0;
        #1;
        check_eq("q_before_read_edge", Q, '0);
        @(posedge CLK);
        #1;
        check_eq("read_05_full", Q, D1);

        // Byte-lane masked write on the upper 64-bit half.
        wr(6'h10, ONES, '0);
        wr(6'h10, {64'h11223344_55667788, 64'h0}, ~{64'h00000000_000000FF, 64'h0});
        check_eq("q_held_masked_write", Q, D1);
        rd(6'h10);
        check_eq("read_10_masked", Q, MASKED);

        // Chip disabled: write-looking inputs must not touch array or Q.
        for (int i = 0; i < 3; i++) begin
            do_op(1'b1, 1'b0, '0, 6'h05, {8{16'hAAAA}});
            check_eq($sformatf("cen_hold_q_%0d", i), Q, MASKED);
        end
        do_op(1'b1, 1'b1, ONES, 6'h05, '0);
        check_eq("cen_hold_q_rd", Q, MASKED);
        rd(6'h05);
        check_eq("cen_no_write_05", Q, D1);

        // Boundary addresses with distinct patterns.
        for (int i = 0; i < 4; i++) begin
            pat = {16{8'({2'b00, addrs[i]}) + 8'h11}};
            wr(addrs[i], pat, '0);
        end
        rd(6'h3F);
        check_eq("addr_3f", Q, {16{8'h50}});
        rd(6'h00);
        check_eq("addr_00", Q, {16{8'h11}});
        rd(6'h3E);
        check_eq("addr_3e", Q, {16{8'h4F}});
        rd(6'h01);
        check_eq("addr_01", Q, {16{8'h12}});

        // No-op write with every bit masked.
        wr(6'h07, P5A, '0);
        wr(6'h07, '0, ONES);
        rd(6'h07);
        check_eq("noop_write_07", Q, P5A);

        // Alternating write/read on one address every cycle.
        for (int i = 0; i < 4; i++) begin
            pat = {4{32'hC0DE0000 + 32'(i * 32'h1111)}};
            wr(6'h20, pat, '0);
            rd(6'h20);
            check_eq($sformatf("b2b_%0d", i), Q, pat);
        end
        idle();
        check_eq("idle_hold", Q, {4{32'hC0DE3333}});

        // Asynchronous reset mid-cycle while CLK is high and Q is non-zero.
        #2;
        RSTN = 1'b0;
        #1;
        check_eq("async_reset_q", Q, '0);
        @(negedge CLK);
        RSTN = 1'b1;
        rd(6'h05);
        check_eq("array_cleared_05", Q, '0);
        rd(6'h20);
        check_eq("array_cleared_20", Q, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_s011hd1p_x32y2d128_bw.md
Name: sram_s011hd1p_x32y2d128_bw

Overview:
- Behavioural model of a single-port synchronous SRAM macro: 64 words x 128 bits, with per-bit write enable.
- Cache data arrays instantiate it: 2 ways x 4 banks, each bank holding one 128-bit line slice per 6-bit set index.
- All control inputs are active-low, matching the hard macro's pin convention.
- Read data is registered, giving one-cycle read latency.

Parameters:
- ADDR_WIDTH, 6, word address width; DEPTH = 2**ADDR_WIDTH = 64.
- DATA_WIDTH, 128, word width and bit-write-enable width.

Ports:
- CLK  input  1  clock; all array and output-register updates occur on the rising edge.
- RSTN  input  1  reset, asynchronous, active-low.
- CEN  input  1  chip enable, active-low; 1 = macro idle.
- WEN  input  1  write enable, active-low; 0 = write cycle, 1 = read cycle (only when CEN=0).
- BWEN  input  DATA_WIDTH  bit write enable, active-low per bit; 0 = bit written, 1 = bit preserved.
- A  input  ADDR_WIDTH  word address.
- D  input  DATA_WIDTH  write data.
- Q  output  DATA_WIDTH  registered read data.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (RSTN=0, asynchronous assertion):
  - Q forced to 0 immediately.
  - All 64 array words cleared to 0.
  - Held while RSTN=0; CLK edges are ignored during reset.
  - Release is synchronous-safe: the first operation is sampled on the first rising CLK edge with RSTN=1.
- Cycle decode at each rising CLK edge (RSTN=1):
  - CEN=1: no access. Array unchanged, Q holds its previous value. WEN, BWEN, A and D are don't-care.
  - CEN=0, WEN=1 (read): Q <= mem[A]. Q is valid from the edge that samples the request, i.e. one-cycle latency. Q then holds until the next read or reset.
  - CEN=0, WEN=0 (write): mem[A] <= (D & ~BWEN) | (mem[A] & BWEN), bitwise.
    - Q is not updated on a write cycle; it keeps the last read value. No write-through.
    - BWEN all ones: the write is a no-op on the array.
    - BWEN all zeros: full 128-bit overwrite.
- Back-to-back accesses:
  - Write then read of the same address on consecutive edges: the read returns the newly written data.
  - Read and write never coincide, since a single port carries one operation per cycle.
- Address: A covers exactly 0..63; there is no out-of-range case and no wrap.
- Inputs sampled only at the rising edge; there is no combinational path from any input to Q.
- Unknown values: if CEN or WEN is X/Z at an edge, the model sets Q to all-X and leaves the array unchanged (simulation only).
- Reset mid-operation: an access pending at the edge coincident with RSTN assertion is discarded; reset wins.

Test Plan:
- Reset and first read:
  - Hold RSTN=0 for 2 cycles, release, then read A=0x00 and A=0x3F.
  - Q=0 during reset and Q=0 after each read.
  - Assert RSTN=0 asynchronously mid-cycle with Q non-zero: Q drops to 0 without a CLK edge.
- Full write / read latency:
  - Write A=0x05, D=0x0123456789ABCDEF_FEDCBA9876543210, BWEN=0; next cycle read A=0x05.
  - Q equals D on the edge after the read request, not before.
  - Q unchanged during the write cycle.
- Byte-masked writes, 64-bit lane at offset 8 (cache store path):
  - Preload A=0x10 with all ones.
  - Write D={64'h11223344_55667788, 64'h0}, BWEN=~{64'h00000000_000000FF, 64'h0}.
  - Read A=0x10: Q=0xFFFFFFFF_FFFFFF88_FFFFFFFF_FFFFFFFF.
- Chip disable:
  - With CEN=1, drive WEN=0, BWEN=0, D=0xAAAA..., A=0x05.
  - Subsequent read of A=0x05 returns the prior data.
  - Q held constant across all CEN=1 cycles.
- Address independence and boundaries:
  - Write distinct patterns (e.g. word index replicated) to A=0x00, 0x01, 0x3E, 0x3F.
  - Read all four back in any order; each returns only its own pattern.
- No-op write and back-to-back:
  - Write with BWEN all ones to A=0x07 holding 0x5A..5A: a read returns 0x5A..5A.
  - Write/read/write/read alternating on the same address every cycle: each read returns the immediately preceding write.
